// File: rtl/dataram_ctrl.sv
// dataram_ctrl: arbitrates two requesters onto the MCU51 internal data RAM,
// maps 8051 bit addresses to byte/position and sequences read-modify-write ops.
module dataram_ctrl #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [7:0] adr0,
  input  logic [7:0] wd0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [7:0] adr1,
  input  logic [7:0] wd1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       busy,
  output logic       mem_cs_n,
  output logic       mem_rw,
  output logic       mem_bb,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_pos,
  output logic [7:0] mem_din,
  output logic       mem_bin,
  input  logic [7:0] mem_dout,
  input  logic       mem_bout
);

  localparam logic [2:0] OP_RDB   = 3'b000;
  localparam logic [2:0] OP_WRB   = 3'b001;
  localparam logic [2:0] OP_RDBIT = 3'b010;
  localparam logic [2:0] OP_WRBIT = 3'b011;
  localparam logic [2:0] OP_SET   = 3'b100;
  localparam logic [2:0] OP_CLR   = 3'b101;
  localparam logic [2:0] OP_CPL   = 3'b110;
  localparam logic [2:0] OP_INC   = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_ACK} state_t;

  state_t     state_q, state_d;
  logic       port_q, port_d, rr_q, rr_d, rej_q, rej_d;
  logic [2:0] op_q, op_d;
  logic [7:0] adr_q, adr_d, wd_q, wd_d, cap_q, cap_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, busy_q, busy_d;
  logic       cs_n_q, cs_n_d, rw_q, rw_d, bb_q, bb_d, bin_q, bin_d;
  logic [7:0] rdata_q, rdata_d, addr_q, addr_d, pos_q, pos_d, din_q, din_d;
  logic       sel_c;

  function automatic logic is_byte(input logic [2:0] op);
    return (op == OP_RDB) || (op == OP_WRB) || (op == OP_INC);
  endfunction

  // rr_q names the preferred port when both request
  always_comb begin
    if (FIXED_PRIO != 0)       sel_c = ~req0;
    else if (req0 && req1)     sel_c = rr_q;
    else                       sel_c = ~req0;
  end

  // Outputs are decoded from the next state so they line up with state_q
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rr_d    = rr_q;
    rej_d   = rej_q;
    op_d    = op_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    cap_d   = cap_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = 8'h00;
    err_d   = 1'b0;
    cs_n_d  = 1'b1;
    rw_d    = 1'b1;
    bb_d    = bb_q;
    addr_d  = addr_q;
    pos_d   = pos_q;
    din_d   = din_q;
    bin_d   = bin_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          port_d = sel_c;
          rr_d   = ~sel_c;
          op_d   = sel_c ? op1 : op0;
          adr_d  = sel_c ? adr1 : adr0;
          wd_d   = sel_c ? wd1 : wd0;
          rej_d  = adr_d[7];
          if (rej_d)
            state_d = S_ACK;
          else if (op_d inside {OP_WRB, OP_WRBIT, OP_SET, OP_CLR})
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        cap_d   = is_byte(op_q) ? mem_dout : {7'b0, mem_bout};
        state_d = (op_q inside {OP_RDB, OP_RDBIT}) ? S_ACK : S_WR;
      end
      S_WR:    state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    if (state_d inside {S_RD, S_CAP, S_WR}) begin
      cs_n_d = 1'b0;
      rw_d   = (state_d != S_WR);
      bb_d   = is_byte(op_d);
      if (is_byte(op_d)) begin
        addr_d = adr_d;
        pos_d  = 8'hFF;
      end else begin
        addr_d = 8'h20 + {4'b0, adr_d[6:3]};
        pos_d  = 8'(1) << adr_d[2:0];
      end
    end

    if (state_d == S_WR) begin
      case (op_d)
        OP_WRB:   din_d = wd_d;
        OP_INC:   din_d = cap_d + 8'd1;
        OP_WRBIT: bin_d = wd_d[0];
        OP_SET:   bin_d = 1'b1;
        OP_CLR:   bin_d = 1'b0;
        OP_CPL:   bin_d = ~cap_d[0];
        default:  ;
      endcase
    end

    if (state_d == S_ACK) begin
      ack0_d = ~port_d;
      ack1_d = port_d;
      err_d  = rej_d;
      if (!rej_d) begin
        case (op_d)
          OP_RDB:           rdata_d = cap_d;
          OP_RDBIT, OP_CPL: rdata_d = {7'b0, cap_d[0]};
          OP_INC:           rdata_d = cap_d + 8'd1;
          default:          rdata_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      rr_q    <= 1'b0;
      rej_q   <= 1'b0;
      op_q    <= 3'b000;
      adr_q   <= 8'h00;
      wd_q    <= 8'h00;
      cap_q   <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rw_q    <= 1'b1;
      bb_q    <= 1'b1;
      addr_q  <= 8'h00;
      pos_q   <= 8'h00;
      din_q   <= 8'h00;
      bin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rr_q    <= rr_d;
      rej_q   <= rej_d;
      op_q    <= op_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      cap_q   <= cap_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      rw_q    <= rw_d;
      bb_q    <= bb_d;
      addr_q  <= addr_d;
      pos_q   <= pos_d;
      din_q   <= din_d;
      bin_q   <= bin_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign mem_cs_n = cs_n_q;
  assign mem_rw   = rw_q;
  assign mem_bb   = bb_q;
  assign mem_addr = addr_q;
  assign mem_pos  = pos_q;
  assign mem_din  = din_q;
  assign mem_bin  = bin_q;

endmodule
